// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// access-size encodings, controller state encoding and lane helpers.
package dcache_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_WAIT = 2'd2,
    WR_REQ    = 2'd3
  } state_t;

  // Byte-enable mask for a store of the given size at the given byte offset.
  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'(4'b0001 << off);
      SZ_HALF: m = 4'(4'b0011 << off);
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Copy right-aligned store data into every lane so the mask picks the right one.
  function automatic logic [31:0] lane_replicate(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Accesses the cache refuses: reserved size or natural-alignment violation.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/data/valid storage for the data cache: one write port with byte
// enables and one asynchronous read port. Valid bits clear on reset.
module dcache_array #(
  parameter int unsigned LINES = 64,
  parameter int unsigned TW    = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] widx,
  input  logic [TW-1:0]            wtag,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wmask,
  input  logic                     set_valid,
  input  logic [$clog2(LINES)-1:0] ridx,
  output logic [TW-1:0]            rtag,
  output logic [31:0]              rdata,
  output logic                     rvalid
);

  logic [31:0]      data_mem [LINES];
  logic [TW-1:0]    tag_mem  [LINES];
  logic [LINES-1:0] valid;

  // Byte-enabled data write; fills use a full mask.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) data_mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Tag is only rewritten when a line is (re)filled.
  always_ff @(posedge clk) begin
    if (we && set_valid) tag_mem[widx] <= wtag;
  end

  // Valid bits: cleared together on reset, set by a fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we && set_valid) begin
      valid[widx] <= 1'b1;
    end
  end

  assign rdata  = data_mem[ridx];
  assign rtag   = tag_mem[ridx];
  assign rvalid = valid[ridx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data
// cache. Read hits are zero-latency; misses and stores stall the core.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 64,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          misalign,
`ifdef DCACHE_STATS_EN
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt,
`endif
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_resp_valid,
  input  logic [31:0]   mem_resp_data
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = AW - IW - 2;

  state_t state, state_nxt;

  logic [IW-1:0] core_idx, fill_idx, arr_widx;
  logic [TW-1:0] core_tag, fill_tag, arr_wtag, arr_rtag;
  logic [31:0]   arr_rdata, arr_wdata, wdata_rep;
  logic [3:0]    arr_wmask, wmask_core;
  logic          arr_rvalid, arr_we, arr_set_valid;
  logic          access, bad, is_wr, is_rd, hit, load;

  assign core_idx   = addr[IW+1:2];
  assign core_tag   = addr[AW-1:IW+2];
  assign fill_idx   = mem_addr[IW+1:2];
  assign fill_tag   = mem_addr[AW-1:IW+2];
  assign wdata_rep  = lane_replicate(size, wdata);
  assign wmask_core = byte_mask(size, addr[1:0]);
  assign access     = re | we;
  assign bad        = access & is_misaligned(size, addr[1:0]);
  assign is_wr      = we & ~bad;
  assign is_rd      = re & ~we & ~bad;
  assign hit        = arr_rvalid & (arr_rtag == core_tag);

  dcache_array #(
    .LINES (LINES),
    .TW    (TW)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (arr_we),
    .widx      (arr_widx),
    .wtag      (arr_wtag),
    .wdata     (arr_wdata),
    .wmask     (arr_wmask),
    .set_valid (arr_set_valid),
    .ridx      (core_idx),
    .rtag      (arr_rtag),
    .rdata     (arr_rdata),
    .rvalid    (arr_rvalid)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, core/memory handshake outputs and array write control.
  always_comb begin
    state_nxt     = state;
    rdata         = arr_rdata;
    stall         = 1'b0;
    misalign      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    load          = 1'b0;
    arr_we        = 1'b0;
    arr_widx      = core_idx;
    arr_wtag      = core_tag;
    arr_wdata     = wdata_rep;
    arr_wmask     = wmask_core;
    arr_set_valid = 1'b0;

    case (state)
      IDLE: begin
        if (bad) begin
          misalign = 1'b1;
        end else if (is_wr) begin
          stall     = 1'b1;
          load      = 1'b1;
          arr_we    = hit;
          state_nxt = WR_REQ;
        end else if (is_rd && !hit) begin
          stall     = 1'b1;
          load      = 1'b1;
          state_nxt = FILL_REQ;
        end
      end
      FILL_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = FILL_WAIT;
      end
      FILL_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          stall         = 1'b0;
          rdata         = mem_resp_data;
          arr_we        = 1'b1;
          arr_widx      = fill_idx;
          arr_wtag      = fill_tag;
          arr_wdata     = mem_resp_data;
          arr_wmask     = 4'b1111;
          arr_set_valid = 1'b1;
          state_nxt     = IDLE;
        end
      end
      WR_REQ: begin
        stall         = ~mem_req_ready;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        if (mem_req_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Reset masks everything the core or memory could act on.
    if (!rst_n) begin
      stall         = 1'b0;
      misalign      = 1'b0;
      mem_req_valid = 1'b0;
      arr_we        = 1'b0;
    end
  end

  // Memory request payload, captured once on leaving IDLE so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (load) begin
      mem_addr  <= {addr[AW-1:2], 2'b00};
      mem_wdata <= wdata_rep;
      mem_wmask <= is_wr ? wmask_core : 4'b1111;
    end
  end

`ifdef DCACHE_STATS_EN
  logic hit_ev, miss_ev;

  assign hit_ev  = rst_n && (state == IDLE) && is_rd && hit;
  assign miss_ev = rst_n && (state == FILL_WAIT) && mem_resp_valid;

  // Saturating hit/miss counters for completed, accepted reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_ev && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 32'd1;
      if (miss_ev && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter LINES, default 64, giving the number of direct-mapped one-word lines (power of two, 4..1024).
REQ-002 SHALL have parameter AW, default 32, giving the byte-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset, which is synchronous and active-low.
REQ-005 SHALL have port re, input, 1, the core read request (load).
REQ-006 SHALL have port we, input, 1, the core write request (WrEn_DM).
REQ-007 SHALL have port size, input, 2, the access size from funct3[1:0] (00 byte, 01 half, 10 word, 11 reserved).
REQ-008 SHALL have port addr, input, AW, the core byte address.
REQ-009 SHALL have port wdata, input, 32, the store data, right-aligned.
REQ-010 SHALL have port rdata, output, 32, the aligned word containing addr; lane extraction is downstream.
REQ-011 SHALL have port stall, output, 1, which freezes the core pipeline while high.
REQ-012 SHALL have port misalign, output, 1, a one-cycle pulse for a rejected access.
REQ-013 SHALL have the memory-side ports mem_req_valid (out, 1), mem_req_ready (in, 1), mem_req_we (out, 1), mem_addr (out, AW, word-aligned), mem_wdata (out, 32) and mem_wmask (out, 4).
REQ-014 SHALL have the memory-side ports mem_resp_valid (in, 1) and mem_resp_data (in, 32).

Function
REQ-015 SHALL map index = addr[log2(LINES)+1:2] and tag = addr[AW-1:log2(LINES)+2], with one valid bit per line.
REQ-016 SHALL use the FSM states IDLE, FILL_REQ, FILL_WAIT and WR_REQ.
REQ-017 SHALL, in IDLE, treat a read hit as zero latency: rdata is valid combinationally in the same cycle and stall stays low.
REQ-018 SHALL, on a read miss in IDLE, assert stall combinationally and go to FILL_REQ.
REQ-019 SHALL, in FILL_REQ, drive mem_req_valid=1 and mem_req_we=0 until mem_req_ready, then go to FILL_WAIT.
REQ-020 SHALL, in FILL_WAIT, on mem_resp_valid write the line and tag, set valid, drive rdata=mem_resp_data and stall=0 in that same cycle, and go to IDLE.
REQ-021 SHALL make writes write-through and no-write-allocate: on we in IDLE, assert stall, update the hit line's enabled bytes and go to WR_REQ.
REQ-022 SHALL, in WR_REQ, hold mem_req_valid=1 and mem_req_we=1 until mem_req_ready; stall SHALL drop in the cycle mem_req_ready is seen, then go to IDLE.
REQ-023 SHALL generate byte masks as: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-024 SHALL replicate wdata into the lanes (byte x4, half x2).
REQ-025 SHALL keep mem_addr, mem_wdata and mem_wmask stable while mem_req_valid=1 and mem_req_ready=0.
REQ-026 SHALL reject an access with size=11, a half access with addr[0]=1, or a word access with addr[1:0]!=0: pulse misalign, issue no memory request, change no state and keep stall low.
REQ-027 SHALL treat re and we both high as a write, with the read ignored.
REQ-028 SHALL ignore core inputs while not in IDLE; the core holds them stable under stall.
REQ-029 SHALL ignore mem_resp_valid outside FILL_WAIT.

Reset
REQ-030 SHALL, with rst_n=0 at a rising edge, clear all valid bits, enter IDLE and zero all counters.
REQ-031 SHALL hold stall=0, misalign=0 and mem_req_valid=0 during reset; rdata is don't-care.
REQ-032 SHALL, on reset mid-transaction, abandon the request; memory-side cleanup is the system's duty.

Configuration
REQ-033 SHALL, with DCACHE_STATS_EN defined, add 32-bit outputs hit_cnt and miss_cnt that saturate at 0xFFFFFFFF and count hits and misses of non-rejected reads when they complete.
REQ-034 SHALL, without DCACHE_STATS_EN, have no such ports and no counter logic.

Structure
REQ-035 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum in the shared package dcache_pkg.
REQ-036 SHALL implement the tag/data/valid storage as the sub-module dcache_array, with one write port and one asynchronous read port.

Verification
REQ-037 SHALL test: reset, then read addr 0x100 with memory returning 0xDEADBEEF after 3 cycles -> one fill request at 0x100, stall high 5 cycles, rdata=0xDEADBEEF.
REQ-038 SHALL test: a repeat read of 0x100 -> stall=0, rdata=0xDEADBEEF, no memory request.
REQ-039 SHALL test: a byte store 0xAA to 0x102 -> mem_wmask=0100, mem_wdata=0xAAAAAAAA, then read 0x100 hits with 0xDEAABEEF.
REQ-040 SHALL test: a half store to 0x101 -> misalign pulse, no memory request, stall=0.
REQ-041 SHALL test: read 0x100 then read 0x200 (same index, LINES=64) -> second read misses and refills, and 0x100 then misses again.
REQ-042 SHALL test: rst_n low during FILL_WAIT -> IDLE next cycle, all lines invalid, and a later response ignored.
